// File: rtl/pru_pkg.sv
// ============================================================================
// pru_pkg
// Shared types for the PRU command sequencer: shape encoding, the queued
// command record, the issue FSM state and the MMIO register offsets.
// Optional feature macro used by the top level: PRU_SEQ_STATS_EN.
// ============================================================================
package pru_pkg;

    // Shape encodings; 2'b11 is also treated as bitmap by the PRU.
    typedef enum logic [1:0] {
        RECT   = 2'b00,
        CIRCLE = 2'b01,
        BITMAP = 2'b10
    } shape_t;

    // One queued draw command (43 bits).
    typedef struct packed {
        logic [9:0] row;
        logic [8:0] col;
        logic [9:0] width;
        logic [8:0] hr;
        shape_t     shape;
        logic [1:0] color;
        logic       subtract;
    } pru_cmd_t;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_DONE,
        RELEASE
    } state_t;

    // Register byte offsets relative to the block base address.
    localparam logic [31:0] OFS_POS  = 32'h0;
    localparam logic [31:0] OFS_SIZE = 32'h4;
    localparam logic [31:0] OFS_GO   = 32'h8;
    localparam logic [31:0] OFS_CTRL = 32'hC;

    // Assemble a command from the staging registers and the GO write bits
    // {subtract, color[1:0], shape[1:0]}.
    function automatic pru_cmd_t make_cmd(
        input logic [9:0] row,
        input logic [8:0] col,
        input logic [9:0] width,
        input logic [8:0] hr,
        input logic [4:0] go_bits
    );
        pru_cmd_t c;
        c.row      = row;
        c.col      = col;
        c.width    = width;
        c.hr       = hr;
        c.shape    = shape_t'(go_bits[1:0]);
        c.color    = go_bits[3:2];
        c.subtract = go_bits[4];
        return c;
    endfunction

endpackage

// File: rtl/pru_cmd_fifo.sv
// ============================================================================
// pru_cmd_fifo
// Single-clock first-word-fall-through FIFO of pru_cmd_t.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   push       write wdata (ignored when full or flushing)
//   pop        retire the head entry (ignored when empty or flushing)
//   flush      discard all entries; overrides push and pop
//   wdata      command to enqueue
//   rdata      head entry, valid whenever empty is 0
//   count      number of stored entries
//   empty/full occupancy flags
// ============================================================================
module pru_cmd_fifo
    import pru_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  pru_cmd_t                 wdata,
    output pru_cmd_t                 rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    pru_cmd_t          mem [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples
    // the pre-edge value of its peers regardless of evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; the pointers and
    // count alone define which entries are valid, and this keeps it a RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= wdata;
    end

    assign rdata = mem[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/pru_cmd_sequencer.sv
// ============================================================================
// pru_cmd_sequencer
// Captures MMIO writes into staging registers, queues draw commands and
// issues them one at a time to the PRU over a start/busy/done handshake.
// start is held until done, then released; the next command waits for done
// to fall so software can post bursts without polling busy.
// Optional feature: define PRU_SEQ_STATS_EN to add cmd_done_cnt, a 16-bit
// wrapping count of completed commands (cleared by rst or CTRL data[2]).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   mmio_we/addr/data        CPU write path (one-cycle strobe)
//   pru_busy, pru_done       PRU status
//   pru_start                start level to the PRU
//   pru_row .. pru_subtract  fields of the command in flight (held after)
//   q_count, q_full          queued entries (excluding in-flight), full flag
//   seq_idle                 queue empty and FSM idle
//   overflow                 sticky: a GO write was dropped
//   cmd_done_cnt             completed-command counter (PRU_SEQ_STATS_EN)
// Registers at BASE_ADDR: +0 CMD_POS, +4 CMD_SIZE, +8 CMD_GO, +C CTRL.
// ============================================================================
module pru_cmd_sequencer
    import pru_pkg::*;
#(
    parameter int          DEPTH     = 8,
    parameter logic [31:0] BASE_ADDR = 32'h4010
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mmio_we,
    input  logic [31:0]              mmio_addr,
    input  logic [31:0]              mmio_data,
    input  logic                     pru_busy,
    input  logic                     pru_done,
    output logic                     pru_start,
    output logic [9:0]               pru_row,
    output logic [8:0]               pru_col,
    output logic [9:0]               pru_width,
    output logic [8:0]               pru_height_radius,
    output logic [1:0]               pru_shape_select,
    output logic [1:0]               pru_color,
    output logic                     pru_subtract,
    output logic [$clog2(DEPTH):0]   q_count,
    output logic                     q_full,
    output logic                     seq_idle,
`ifdef PRU_SEQ_STATS_EN
    output logic [15:0]              cmd_done_cnt,
`endif
    output logic                     overflow
);
    logic       sel_pos, sel_size, sel_go, sel_ctrl;
    logic       flush, ovf_clear, push, pop;

    logic [9:0] pos_row_q, pos_row_d;
    logic [8:0] pos_col_q, pos_col_d;
    logic [9:0] size_w_q, size_w_d;
    logic [8:0] size_hr_q, size_hr_d;
    logic       overflow_q, overflow_d;

    state_t     state_q, state_d;
    logic       start_q, start_d;
    pru_cmd_t   cmd_q, cmd_d;

    pru_cmd_t   push_cmd, head_cmd;
    logic       fifo_empty, fifo_full;
    logic [$clog2(DEPTH):0] fifo_count;

    // Data bits with no register behind them.
    logic       unused_mmio_bits;
    assign unused_mmio_bits = ^{mmio_data[31:25], mmio_data[15:10]};

    // ---------------------------------------------------------------- decode
    assign sel_pos   = mmio_we && (mmio_addr == BASE_ADDR + OFS_POS);
    assign sel_size  = mmio_we && (mmio_addr == BASE_ADDR + OFS_SIZE);
    assign sel_go    = mmio_we && (mmio_addr == BASE_ADDR + OFS_GO);
    assign sel_ctrl  = mmio_we && (mmio_addr == BASE_ADDR + OFS_CTRL);

    assign flush     = sel_ctrl && mmio_data[1];
    assign ovf_clear = sel_ctrl && mmio_data[0];
    // Fullness is judged on this cycle's count, so a pop in the same cycle
    // does not rescue a push into a full queue. A flush discards the push
    // silently (GO and CTRL cannot coincide today, but the priority is set).
    assign push      = sel_go && !flush && !fifo_full;
    assign push_cmd  = make_cmd(pos_row_q, pos_col_q, size_w_q, size_hr_q,
                                mmio_data[4:0]);

    // ------------------------------------------------ staging and overflow
    always_comb begin
        pos_row_d  = pos_row_q;
        pos_col_d  = pos_col_q;
        size_w_d   = size_w_q;
        size_hr_d  = size_hr_q;
        overflow_d = overflow_q;
        if (sel_pos) begin
            pos_row_d = mmio_data[9:0];
            pos_col_d = mmio_data[24:16];
        end
        if (sel_size) begin
            size_w_d  = mmio_data[9:0];
            size_hr_d = mmio_data[24:16];
        end
        if (ovf_clear) begin
            overflow_d = 1'b0;
        end else if (sel_go && !flush && fifo_full) begin
            overflow_d = 1'b1;
        end
    end

    // ------------------------------------------------------------- queue
    pru_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wdata (push_cmd),
        .rdata (head_cmd),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // --------------------------------------------------------------- FSM
    // start is registered: it rises on entry to LAUNCH and falls on the
    // edge after done is seen, giving a glitch-free level to the PRU.
    always_comb begin
        state_d = state_q;
        start_d = start_q;
        cmd_d   = cmd_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                // A flush in this cycle also cancels the head entry.
                if (!fifo_empty && !pru_busy && !pru_done && !flush) begin
                    pop     = 1'b1;
                    cmd_d   = head_cmd;
                    start_d = 1'b1;
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (pru_done) begin
                    start_d = 1'b0;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (!pru_done) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                start_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            start_q    <= 1'b0;
            cmd_q      <= '0;
            pos_row_q  <= '0;
            pos_col_q  <= '0;
            size_w_q   <= '0;
            size_hr_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            start_q    <= start_d;
            cmd_q      <= cmd_d;
            pos_row_q  <= pos_row_d;
            pos_col_q  <= pos_col_d;
            size_w_q   <= size_w_d;
            size_hr_q  <= size_hr_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef PRU_SEQ_STATS_EN
    // ------------------------------------------------------- statistics
    logic [15:0] cmd_done_cnt_q, cmd_done_cnt_d;

    // A software clear takes priority over a completion in the same cycle.
    always_comb begin
        cmd_done_cnt_d = cmd_done_cnt_q;
        if (sel_ctrl && mmio_data[2]) begin
            cmd_done_cnt_d = '0;
        end else if (state_q == WAIT_DONE && pru_done) begin
            cmd_done_cnt_d = cmd_done_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) cmd_done_cnt_q <= '0;
        else     cmd_done_cnt_q <= cmd_done_cnt_d;
    end

    assign cmd_done_cnt = cmd_done_cnt_q;
`endif

    // ------------------------------------------------------------ outputs
    assign pru_start         = start_q;
    assign pru_row           = cmd_q.row;
    assign pru_col           = cmd_q.col;
    assign pru_width         = cmd_q.width;
    assign pru_height_radius = cmd_q.hr;
    assign pru_shape_select  = cmd_q.shape;
    assign pru_color         = cmd_q.color;
    assign pru_subtract      = cmd_q.subtract;
    assign q_count           = fifo_count;
    assign q_full            = fifo_full;
    assign seq_idle          = fifo_empty && (state_q == IDLE);
    assign overflow          = overflow_q;

endmodule
